// File: rtl/cu_access_scheduler.sv
// cu_access_scheduler: round-robin, grant-locked arbiter between IFU and DFU for the shared CU command port
module cu_access_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic ifu2ar_req,
  input  logic dfu2ar_req,
  input  logic ifu2ar_done,
  input  logic dfu2ar_done,
  input  logic cu2ar_busy,
  output logic ar2ifu_grant,
  output logic ar2dfu_grant,
  output logic ar_timeout,
  output logic ar_timeout_src,
  output logic [TO_WIDTH-1:0] ar_wd_count
);
  typedef enum logic [1:0] {IDLE, GNT_IFU, GNT_DFU, GAP} state_t;
  localparam logic [TO_WIDTH-1:0] TERM = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  state_t state, state_nxt;
  logic last_owner;
  logic [TO_WIDTH-1:0] wd_count;
  logic timeout_q, timeout_src_q;
  logic granted, own_req, own_done, wd_term, release_gnt, wd_fire;
  // owner-relative release conditions; done wins over a coincident watchdog expiry
  always_comb begin
    granted = (state == GNT_IFU) || (state == GNT_DFU);
    own_req = (state == GNT_DFU) ? dfu2ar_req : ifu2ar_req;
    own_done = (state == GNT_DFU) ? dfu2ar_done : ifu2ar_done;
    wd_term = wd_count == TERM;
    release_gnt = granted && (own_done || !own_req || wd_term);
    wd_fire = release_gnt && wd_term && !own_done;
  end
  // state, watchdog, round-robin history and timeout flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      last_owner <= 1'b1;
      wd_count <= '0;
      timeout_q <= 1'b0;
      timeout_src_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wd_count <= (granted && !release_gnt && wd_count != '1) ? wd_count + 1'b1 : '0;
      timeout_q <= wd_fire;
      if (wd_fire) timeout_src_q <= state == GNT_DFU;
      if (release_gnt) last_owner <= state == GNT_DFU;
    end
  end
  // next state: grant only from IDLE when CU is free, lock until release, one-cycle gap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (!cu2ar_busy)
          state_nxt = (ifu2ar_req && (!dfu2ar_req || last_owner)) ? GNT_IFU :
                      dfu2ar_req ? GNT_DFU : IDLE;
      GNT_IFU, GNT_DFU: state_nxt = release_gnt ? GAP : state;
      GAP: state_nxt = IDLE;
    endcase
  end
  // outputs decoded straight from registers
  always_comb begin
    ar2ifu_grant = state == GNT_IFU;
    ar2dfu_grant = state == GNT_DFU;
    ar_timeout = timeout_q;
    ar_timeout_src = timeout_src_q;
    ar_wd_count = wd_count;
  end
endmodule

// File: tb/tb_cu_access_scheduler.sv
// tb_cu_access_scheduler: directed scoreboard bench for the IFU/DFU CU port arbiter
module tb_cu_access_scheduler;
  logic clk = 1'b0;
  logic rstn;
  logic ifu2ar_req, dfu2ar_req, ifu2ar_done, dfu2ar_done, cu2ar_busy;
  logic ar2ifu_grant, ar2dfu_grant, ar_timeout, ar_timeout_src;
  logic [15:0] ar_wd_count;
  int total = 0;
  int bad = 0;
  logic [2:0] exp_q[$];

  cu_access_scheduler #(.TIMEOUT_CYCLES(8), .TO_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn),
    .ifu2ar_req(ifu2ar_req), .dfu2ar_req(dfu2ar_req),
    .ifu2ar_done(ifu2ar_done), .dfu2ar_done(dfu2ar_done),
    .cu2ar_busy(cu2ar_busy),
    .ar2ifu_grant(ar2ifu_grant), .ar2dfu_grant(ar2dfu_grant),
    .ar_timeout(ar_timeout), .ar_timeout_src(ar_timeout_src),
    .ar_wd_count(ar_wd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // in = {ifu_req, dfu_req, ifu_done, dfu_done, busy}; exp = {ifu_grant, dfu_grant, timeout} after the edge
  task automatic step(input logic [4:0] in, input logic [2:0] exp, input string tag);
    logic [2:0] e;
    {ifu2ar_req, dfu2ar_req, ifu2ar_done, dfu2ar_done, cu2ar_busy} = in;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, {13'd0, ar2ifu_grant, ar2dfu_grant, ar_timeout}, {13'd0, e});
    chk({tag, "_excl"}, {15'd0, ar2ifu_grant & ar2dfu_grant}, 16'd0);
  endtask

  initial begin
    rstn = 1'b0;
    {ifu2ar_req, dfu2ar_req, ifu2ar_done, dfu2ar_done, cu2ar_busy} = '0;
    #1;
    step(5'b00000, 3'b000, "rst0");
    step(5'b00000, 3'b000, "rst1");
    chk("rst_wd", ar_wd_count, 16'd0);
    chk("rst_src", {15'd0, ar_timeout_src}, 16'd0);
    rstn = 1'b1;
    // IFU alone: grant next cycle, done releases through GAP and IDLE
    step(5'b10000, 3'b100, "t1_grant");
    repeat (4) step(5'b10000, 3'b100, "t1_hold");
    chk("t1_wd", ar_wd_count, 16'd4);
    step(5'b10100, 3'b000, "t1_done_gap");
    step(5'b00000, 3'b000, "t1_idle");
    // contention from reset: IFU first, then strict alternation with two dead cycles
    rstn = 1'b0;
    step(5'b00000, 3'b000, "t2_rst");
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(5'b11000, k[0] ? 3'b010 : 3'b100, "t2_grant");
      repeat (3) step(5'b11000, k[0] ? 3'b010 : 3'b100, "t2_hold");
      step(k[0] ? 5'b11010 : 5'b11100, 3'b000, "t2_gap");
      step(5'b11000, 3'b000, "t2_idle");
    end
    // watchdog: DFU holds 8 cycles, timeout pulse, IFU granted two cycles later
    step(5'b01000, 3'b010, "t3_grant");
    repeat (7) step(5'b11000, 3'b010, "t3_hold");
    chk("t3_wd_term", ar_wd_count, 16'd7);
    step(5'b11000, 3'b001, "t3_timeout");
    chk("t3_src", {15'd0, ar_timeout_src}, 16'd1);
    chk("t3_wd_gap", ar_wd_count, 16'd0);
    step(5'b11000, 3'b000, "t3_idle");
    step(5'b11000, 3'b100, "t3_ifu");
    step(5'b01000, 3'b000, "t3_abandon");
    chk("t3_src_hold", {15'd0, ar_timeout_src}, 16'd1);
    step(5'b00000, 3'b000, "t3_idle2");
    // busy blocks new grants only
    repeat (10) step(5'b10001, 3'b000, "t4_busy");
    step(5'b10000, 3'b100, "t4_go");
    repeat (3) step(5'b10001, 3'b100, "t4_busy_mid");
    step(5'b10101, 3'b000, "t4_done");
    step(5'b00000, 3'b000, "t4_idle");
    // DFU abandon after 3 cycles, stray IFU done ignored
    step(5'b01000, 3'b010, "t5_grant");
    step(5'b01100, 3'b010, "t5_stray");
    step(5'b01000, 3'b010, "t5_hold");
    step(5'b00000, 3'b000, "t5_abandon");
    step(5'b00000, 3'b000, "t5_idle");
    // reset mid-grant drops grant at once, then done/terminal-count tie gives no pulse
    step(5'b10000, 3'b100, "t6_grant");
    step(5'b10000, 3'b100, "t6_hold0");
    rstn = 1'b0;
    step(5'b10000, 3'b000, "t6_rst");
    chk("t6_rst_src", {15'd0, ar_timeout_src}, 16'd0);
    rstn = 1'b1;
    step(5'b10000, 3'b100, "t6_regrant");
    repeat (7) step(5'b10000, 3'b100, "t6_hold");
    chk("t6_wd_term", ar_wd_count, 16'd7);
    step(5'b10100, 3'b000, "t6_tie");
    chk("t6_tie_src", {15'd0, ar_timeout_src}, 16'd0);
    step(5'b00000, 3'b000, "t6_idle");
    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cu_access_scheduler.md
Name: cu_access_scheduler

Overview:
- Arbitrates the shared CU command port between the IFU and DFU requesters.
- Issues a registered grant and holds it, locked, until the owner signals transaction completion, drops its request, or a watchdog expires.
- Resolves contention round-robin and enforces a one-cycle dead gap between owners.
- Its grant outputs drive the existing IFU/DFU-to-CU steering muxes.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles a grant may be held before forced release; legal range 2 to 2^TO_WIDTH-1.
- TO_WIDTH, 16: width of the watchdog counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- ifu2ar_req  input  1  IFU requests the CU port; level, held until grant or abandon.
- dfu2ar_req  input  1  DFU requests the CU port; level.
- ifu2ar_done  input  1  single-cycle pulse: IFU transaction complete; valid only while IFU granted.
- dfu2ar_done  input  1  single-cycle pulse: DFU transaction complete; valid only while DFU granted.
- cu2ar_busy  input  1  CU cannot accept a new owner; blocks new grants only.
- ar2ifu_grant  output  1  IFU owns the CU port (registered).
- ar2dfu_grant  output  1  DFU owns the CU port (registered).
- ar_timeout  output  1  single-cycle pulse: watchdog forced release.
- ar_timeout_src  output  1  owner at last timeout (0=IFU, 1=DFU); holds value until next timeout.
- ar_wd_count  output  TO_WIDTH  current watchdog count, for debug.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - state=IDLE; all outputs 0.
  - last_owner=DFU, so IFU wins the first contention.
  - Reset mid-grant drops the grant on the next edge with no gap and no timeout pulse.
- States: IDLE, GNT_IFU, GNT_DFU, GAP.
- IDLE:
  - If cu2ar_busy=1, stay in IDLE.
  - Else, only IFU requesting -> GNT_IFU; only DFU requesting -> GNT_DFU.
  - Both requesting -> the requester that is not last_owner.
  - Neither requesting -> stay.
  - Grant output rises on the edge that enters GNT_x, i.e. one cycle after the request is sampled.
- GNT_x:
  - Grant x=1, other grant=0, guaranteed mutually exclusive.
  - ar_wd_count clears to 0 on entry and increments by 1 each cycle in state.
  - Exit to GAP on any of: x_done=1; x_req=0 (abandon); ar_wd_count==TIMEOUT_CYCLES-1.
  - On the timeout exit only: ar_timeout=1 for the cycle GAP is entered, and ar_timeout_src=x.
  - done and timeout in the same cycle: treated as done; no timeout pulse.
  - The other requester's activity and cu2ar_busy are ignored while granted; there is no preemption.
  - A done pulse from the non-owner is ignored.
- GAP:
  - Lasts exactly 1 cycle with both grants 0.
  - last_owner=x; ar_wd_count cleared; then -> IDLE.
- Minimum grant-to-grant spacing: GNT -> GAP -> IDLE -> GNT, i.e. 2 cycles of both grants low between owners.
- Watchdog counter saturates and never wraps. Terminal count TIMEOUT_CYCLES-1 means the grant is high for exactly TIMEOUT_CYCLES cycles.
- Requests are not latched: a request that deasserts before being granted is lost.

Test Plan:
- Reset then IFU-only: rstn low 2 cycles; ifu2ar_req=1 at cycle 0 -> ar2ifu_grant=1 from cycle 1; ifu2ar_done at cycle 5 -> grant 0 at cycle 6, both grants 0 at cycles 6-7.
- Contention round-robin: both reqs held high, done pulsed 3 cycles after each grant -> grant sequence IFU, DFU, IFU, DFU; never both high; 2 idle cycles between owners.
- Watchdog: TIMEOUT_CYCLES=8, DFU granted and never signals done -> ar2dfu_grant high exactly 8 cycles; ar_timeout pulses 1 cycle; ar_timeout_src=1; IFU, if requesting, is granted 2 cycles later.
- Busy blocking: cu2ar_busy=1 with ifu2ar_req=1 for 10 cycles -> no grant. Busy drops -> grant next cycle. Busy raised mid-grant -> grant unaffected.
- Abandon and stray done: DFU granted, dfu2ar_req drops at cycle 3 -> release via GAP with no timeout pulse. ifu2ar_done pulsed while DFU owns -> no effect.
- Reset mid-grant and done/timeout tie: rstn=0 while IFU granted -> grant 0 next edge, ar_timeout stays 0. Done asserted on the terminal-count cycle -> ar_timeout stays 0.
